ts_tx_ser: RTL

- Downstream stage of the TS generator.
- Accepts 128-bit TS ordered sets (16 symbols, symbol 0 in bits [127:120]) on a valid-only interface and buffers them in a small FIFO.
- Serializes each ordered set onto a one-symbol-per-clock lane interface, flagging K-characters, under PHY backpressure.
- Generates the TS generator's full flag with enough margin to absorb its registered valid.

---
 rtl/ts_tx_ser_pkg.sv | 23 ++
 rtl/ts_tx_fifo.sv | 56 +++++
 rtl/ts_tx_ser.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ts_tx_ser_pkg.sv
// Shared TS symbol definitions and serializer types for the TS transmit path.
package ts_tx_ser_pkg;

    localparam int SYM_W  = 8;
    localparam int TS_LEN = 16;
    localparam int TS_W   = SYM_W * TS_LEN;
    localparam int IDX_W  = $clog2(TS_LEN);

    localparam logic [SYM_W-1:0] COM = 8'hBC;
    localparam logic [SYM_W-1:0] PAD = 8'hF7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

    // COM only marks symbol 0; PAD is a K-character only in the link/lane number slots.
    function automatic logic is_k_sym(input logic [IDX_W-1:0] idx, input logic [SYM_W-1:0] sym);
        return ((idx == '0) && (sym == COM)) ||
               (((idx == IDX_W'(1)) || (idx == IDX_W'(2))) && (sym == PAD));
    endfunction

endpackage

// File: rtl/ts_tx_fifo.sv
// Ordered-set FIFO: registered count, same-cycle flush, push and pop may coincide even when full.
module ts_tx_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 128,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          push_ok,
    output logic          pop_ok
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty & ~flush;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok = push & ~flush & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/ts_tx_ser.sv
// TS transmit serializer: buffers 128-bit ordered sets and emits one symbol per clock with K flags.
module ts_tx_ser
    import ts_tx_ser_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ts_valid,
    input  logic [TS_W-1:0]  ts,
    output logic             ts_tx_fifo_full,
    input  logic             flush,
    input  logic             tx_rdy,
    output logic [SYM_W-1:0] tx_sym,
    output logic             tx_k,
    output logic             tx_vld,
    output logic             tx_os_start,
    output logic             ts_sent,
    output logic [CNT_W-1:0] ts_sent_cnt,
    output logic             ovf_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] AFULL_TH = CW'(DEPTH - AFULL_MARGIN);

    ser_state_e       state, state_nxt;
    logic [TS_W-1:0]  shreg, shreg_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             pop_req;
    logic             sent;

    logic [TS_W-1:0]  fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    count_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_ok;
    logic             pop_ok;
    logic             fifo_avail;

    ts_tx_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (ts_valid),
        .din     (ts),
        .pop     (pop_req),
        .flush   (flush),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .push_ok (push_ok),
        .pop_ok  (pop_ok)
    );

    // Entries being flushed this cycle must never reach the line.
    assign fifo_avail = ~fifo_empty & ~flush;
    assign count_nxt  = flush ? '0 : (fifo_count + CW'(push_ok) - CW'(pop_ok));

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        pop_req   = 1'b0;
        sent      = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_avail) begin
                    pop_req   = 1'b1;
                    shreg_nxt = fifo_dout;
                    idx_nxt   = '0;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_rdy) begin
                    if (idx == IDX_W'(TS_LEN - 1)) begin
                        sent    = 1'b1;
                        idx_nxt = '0;
                        if (fifo_avail) begin
                            pop_req   = 1'b1;
                            shreg_nxt = fifo_dout;
                        end else begin
                            shreg_nxt = '0;
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        shreg_nxt = {shreg[TS_W-SYM_W-1:0], {SYM_W{1'b0}}};
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            shreg           <= '0;
            idx             <= '0;
            ts_sent_cnt     <= '0;
            ts_tx_fifo_full <= 1'b0;
            ovf_err         <= 1'b0;
        end else begin
            state           <= state_nxt;
            shreg           <= shreg_nxt;
            idx             <= idx_nxt;
            ts_tx_fifo_full <= (count_nxt >= AFULL_TH);
            if (flush)
                ts_sent_cnt <= '0;
            else if (sent && (ts_sent_cnt != '1))
                ts_sent_cnt <= ts_sent_cnt + CNT_W'(1);
            if (ts_valid && !flush && fifo_full && !pop_ok)
                ovf_err <= 1'b1;
        end
    end

    assign tx_vld      = (state == S_SEND);
    assign tx_sym      = tx_vld ? shreg[TS_W-1 -: SYM_W] : '0;
    assign tx_k        = tx_vld & is_k_sym(idx, shreg[TS_W-1 -: SYM_W]);
    assign tx_os_start = tx_vld & (idx == '0);
    assign ts_sent     = sent;

endmodule
